// File: rtl/display_pkg.sv
// Shared constants and helpers for the scrolling 7-segment display controller.
// Anode patterns are active-low with an3 in bit 3.
package display_pkg;

    localparam int MSG_LEN = 16;

    localparam logic [3:0] AN_OFF = 4'b1111;
    localparam logic [3:0] AN3_ON = 4'b0111;
    localparam logic [3:0] AN2_ON = 4'b1011;
    localparam logic [3:0] AN1_ON = 4'b1101;
    localparam logic [3:0] AN0_ON = 4'b1110;

    typedef enum logic [1:0] {
        POS_AN3 = 2'd0,
        POS_AN2 = 2'd1,
        POS_AN1 = 2'd2,
        POS_AN0 = 2'd3
    } pos_e;

    function automatic logic [3:0] anode_for(input pos_e pos);
        case (pos)
            POS_AN3: return AN3_ON;
            POS_AN2: return AN2_ON;
            POS_AN1: return AN1_ON;
            POS_AN0: return AN0_ON;
            default: return AN_OFF;
        endcase
    endfunction

    function automatic logic [3:0] msg_init(input int idx);
        return 4'(idx);
    endfunction

endpackage

// File: rtl/msg_buffer.sv
// 16-entry x 4-bit message register file: synchronous write, combinational read.
// Reset reloads the identity message (entry i holds code i).
module msg_buffer
    import display_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_wr_en,
    input  logic [3:0] i_wr_addr,
    input  logic [3:0] i_wr_data,
    input  logic [3:0] i_rd_addr,
    output logic [3:0] o_rd_data
);

    logic [3:0] r_mem [MSG_LEN];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                r_mem[i] <= msg_init(i);
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/scroll_display_ctrl.sv
// Digit-scan and message-scroll controller for a 4-digit 7-segment display.
// Outputs are registered from next-state values so they line up with the slot counters.
module scroll_display_ctrl
    import display_pkg::*;
#(
    parameter int DIGIT_CYCLES  = 16,
    parameter int BLANK_CYCLES  = 2,
    parameter int SCROLL_FRAMES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic       pause,
    input  logic       dir,
    output logic       an3,
    output logic       an2,
    output logic       an1,
    output logic       an0,
    output logic [3:0] char,
    output logic       frame_tick
);

    localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int FW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
    localparam logic [CW-1:0] LAST_CYC = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_C  = CW'(BLANK_CYCLES);
    localparam logic [FW-1:0] LAST_FRM = FW'(SCROLL_FRAMES - 1);

    logic [CW-1:0] r_cyc;
    pos_e          r_slot;
    logic [FW-1:0] r_frame;
    logic [3:0]    r_offset;
    logic [3:0]    r_an;
    logic [3:0]    r_char;
    logic          r_tick;

    logic          w_slot_last;
    logic          w_frame_end;
    logic [CW-1:0] w_cyc_next;
    pos_e          w_slot_next;
    logic [FW-1:0] w_frame_next;
    logic [3:0]    w_offset_next;
    logic [3:0]    w_rd_addr;
    logic [3:0]    w_rd_data;

    assign w_slot_last = (r_cyc == LAST_CYC);
    assign w_frame_end = w_slot_last && (r_slot == POS_AN0);
    assign w_cyc_next  = w_slot_last ? '0 : r_cyc + CW'(1);
    assign w_slot_next = w_slot_last ? pos_e'(2'(r_slot + 2'd1)) : r_slot;

    // Scroll decision happens only on the frame's final cycle, so pause/dir
    // changes mid-frame are ignored until then.
    always_comb begin
        w_frame_next  = r_frame;
        w_offset_next = r_offset;
        if (w_frame_end && !pause) begin
            if (r_frame == LAST_FRM) begin
                w_frame_next  = '0;
                w_offset_next = dir ? (r_offset - 4'd1) : (r_offset + 4'd1);
            end else begin
                w_frame_next = r_frame + FW'(1);
            end
        end
    end

    // Look up with the next offset so a new frame's first slot already uses it.
    assign w_rd_addr = w_offset_next + {2'b00, w_slot_next};

    msg_buffer u_msg_buffer (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (wr_en),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cyc    <= '0;
            r_slot   <= POS_AN3;
            r_frame  <= '0;
            r_offset <= '0;
            r_an     <= AN_OFF;
            r_char   <= 4'd0;
            r_tick   <= 1'b0;
        end else begin
            r_cyc    <= w_cyc_next;
            r_slot   <= w_slot_next;
            r_frame  <= w_frame_next;
            r_offset <= w_offset_next;
            r_an     <= (w_cyc_next < BLANK_C) ? AN_OFF : anode_for(w_slot_next);
            r_tick   <= (w_slot_next == POS_AN0) && (w_cyc_next == LAST_CYC);
            // Latch the character only at slot boundaries so writes never glitch a live digit.
            if (w_slot_last) begin
                r_char <= w_rd_data;
            end
        end
    end

    assign an3        = r_an[3];
    assign an2        = r_an[2];
    assign an1        = r_an[1];
    assign an0        = r_an[0];
    assign char       = r_char;
    assign frame_tick = r_tick;

endmodule
